// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between the requesting units and the ring round-robin arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface ring_rr_arbiter_if #(
    parameter int N   = 5,
    parameter int IDW = 3
);
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic [N-1:0]   token;
    logic           timeout;

    modport master (
        output req, done,
        input  gnt, gnt_valid, gnt_id, token, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_valid, gnt_id, token, timeout
    );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot token ring; a grant is held until the owner releases it.
// Define ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles (timeout pulse).
module ring_rr_arbiter #(
    parameter int N        = 5,
    parameter int IDW      = 3,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    ring_rr_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [N-1:0]   r_token;
    logic [N-1:0]   r_gnt;
    logic [IDW-1:0] r_owner;
    logic [IDW-1:0] w_tokIdx;
    logic [IDW-1:0] w_nextIdx;
    logic [IDW-1:0] w_startIdx;
    logic [IDW-1:0] w_winIdx;
    logic           w_anyReq;
    logic           w_release;
    logic           w_forced;
    logic           w_timeout;

    if (N < 2 || N > 8 || IDW != $clog2(N) || MAX_HOLD < 1) begin : g_badParam
        $error("ring_rr_arbiter: illegal parameter combination");
    end

    assign w_anyReq   = |bus.req;
    assign w_release  = bus.done[r_owner] || !bus.req[r_owner];
    assign w_nextIdx  = (r_owner == IDW'(N - 1)) ? '0 : r_owner + IDW'(1);
    // The dead cycle already arbitrates from the advanced position, before the token register catches up
    assign w_startIdx = (r_state == RELEASE) ? w_nextIdx : w_tokIdx;

    always_comb begin
        w_tokIdx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (r_token[i]) w_tokIdx = IDW'(i);
        end
        if (!$onehot(r_token)) w_tokIdx = '0;
    end

    // Descending scan so the lowest ring distance from the start index is written last
    always_comb begin
        int             cand;
        logic [IDW-1:0] candIdx;
        w_winIdx = '0;
        cand     = 0;
        candIdx  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            cand = int'(w_startIdx) + off;
            if (cand >= N) cand = cand - N;
            candIdx = IDW'(cand);
            if (bus.req[candIdx]) w_winIdx = candIdx;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD + 1);

    logic [CW-1:0] r_holdCnt;
    logic          r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_holdCnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_holdCnt <= (r_state == GRANT) ? r_holdCnt + CW'(1) : '0;
            r_timeout <= w_forced;
        end
    end

    assign w_forced  = (r_state == GRANT) && (r_holdCnt == CW'(MAX_HOLD - 1)) && !w_release;
    assign w_timeout = r_timeout;
`else
    assign w_forced  = 1'b0;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_anyReq) w_nextState = GRANT;
            GRANT:   if (w_release || w_forced) w_nextState = RELEASE;
            RELEASE: w_nextState = w_anyReq ? GRANT : IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt   <= '0;
            r_owner <= '0;
            r_token <= N'(1);
        end else begin
            if (w_nextState == GRANT && r_state != GRANT) begin
                r_gnt   <= N'(1) << w_winIdx;
                r_owner <= w_winIdx;
            end else if (w_nextState != GRANT) begin
                r_gnt <= '0;
            end
            if (r_state == RELEASE)     r_token <= N'(1) << w_nextIdx;
            else if (!$onehot(r_token)) r_token <= N'(1);
        end
    end

    always_comb begin
        bus.gnt       = r_gnt;
        bus.gnt_valid = |r_gnt;
        bus.gnt_id    = (|r_gnt) ? r_owner : '0;
        bus.token     = r_token;
        bus.timeout   = w_timeout;
    end

endmodule
